// File: rtl/mpm_port_scheduler.sv
// mpm_port_scheduler: rotating-priority, hazard-aware sharing of PORTS memory
// ports among REQS requesters, with tagged read-data return routing.
// In: req_valid/we/addr/d per requester, mem_q per port. Out: req_ready
// (comb grant), rsp_valid/rsp_data, registered mem_addr/mem_en/mem_d,
// stat_grants/stat_conflicts (live only when MPM_SCHED_STATS_EN is defined).
module mpm_port_scheduler #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 512,
  parameter int PORTS   = 4,
  parameter int REQS    = 8,
  parameter int MEM_LAT = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = $clog2(REQS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQS-1:0]  req_valid,
  input  logic [REQS-1:0]  req_we,
  input  logic [AW-1:0]    req_addr [REQS],
  input  logic [WIDTH-1:0] req_d [REQS],
  output logic [REQS-1:0]  req_ready,
  output logic [REQS-1:0]  rsp_valid,
  output logic [WIDTH-1:0] rsp_data [REQS],
  output logic [AW-1:0]    mem_addr [PORTS],
  output logic [PORTS-1:0] mem_en,
  output logic [WIDTH-1:0] mem_d [PORTS],
  input  logic [WIDTH-1:0] mem_q [PORTS],
  output logic [31:0]      stat_grants,
  output logic [31:0]      stat_conflicts
);
  localparam int TL = MEM_LAT + 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PORTS-1:0] s_v, s_we;
  logic [AW-1:0]    s_addr [PORTS];
  logic [WIDTH-1:0] s_d [PORTS];
  logic [PW-1:0]    s_idx [PORTS];
  logic [PW:0]      n_gnt, n_conf;
  logic [PW:0]      idx_w;
  logic [PW-1:0]    idx;
  logic             haz, found;

  // Scan from ptr; each granted request claims the next free port slot.
  always_comb begin
    req_ready = '0;
    ptr_d     = ptr_q;
    s_v       = '0;
    s_we      = '0;
    for (int p = 0; p < PORTS; p++) begin
      s_addr[p] = '0;
      s_d[p]    = '0;
      s_idx[p]  = '0;
    end
    n_gnt  = '0;
    n_conf = '0;
    idx_w  = '0;
    idx    = '0;
    haz    = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < REQS; k++) begin
      idx_w = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(REQS))
        idx_w = idx_w - (PW+1)'(REQS);
      idx = idx_w[PW-1:0];
      // Any same-address pair involving a write is a hazard;
      // read-read to one address is harmless.
      haz = 1'b0;
      for (int j = 0; j < PORTS; j++)
        if (s_v[j] && s_addr[j] == req_addr[idx]
            && (s_we[j] || req_we[idx]))
          haz = 1'b1;
      if (req_valid[idx]) begin
        if (n_gnt < (PW+1)'(PORTS) && !haz) begin
          req_ready[idx] = 1'b1;
          for (int p = 0; p < PORTS; p++)
            if (n_gnt == (PW+1)'(p)) begin
              s_v[p]    = 1'b1;
              s_we[p]   = req_we[idx];
              s_addr[p] = req_addr[idx];
              s_d[p]    = req_d[idx];
              s_idx[p]  = idx;
            end
          n_gnt = n_gnt + 1'b1;
        end else begin
          // Only hazard losses count; losses to a full port set do not.
          if (n_gnt < (PW+1)'(PORTS))
            n_conf = n_conf + 1'b1;
          if (!found) begin
            found = 1'b1;
            ptr_d = idx;
          end
        end
      end
    end
  end

  logic [PORTS-1:0] mem_en_q, mem_en_d;
  logic [AW-1:0]    mem_addr_q [PORTS];
  logic [AW-1:0]    mem_addr_d [PORTS];
  logic [WIDTH-1:0] mem_d_q [PORTS];
  logic [WIDTH-1:0] mem_d_d [PORTS];
  logic [PORTS-1:0] tag_v_q [TL];
  logic [PORTS-1:0] tag_v_d [TL];
  logic [PW-1:0]    tag_i_q [TL][PORTS];
  logic [PW-1:0]    tag_i_d [TL][PORTS];

  // Stage 0 of the tag pipe lines up with the registered command;
  // stage MEM_LAT lines up with mem_q.
  always_comb begin
    mem_en_d   = s_v & s_we;
    tag_v_d[0] = s_v & ~s_we;
    for (int p = 0; p < PORTS; p++) begin
      mem_addr_d[p] = s_addr[p];
      mem_d_d[p]    = s_we[p] ? s_d[p] : '0;
      tag_i_d[0][p] = s_idx[p];
    end
    for (int s = 1; s < TL; s++) begin
      tag_v_d[s] = tag_v_q[s-1];
      for (int p = 0; p < PORTS; p++)
        tag_i_d[s][p] = tag_i_q[s-1][p];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      mem_en_q <= '0;
      for (int p = 0; p < PORTS; p++) begin
        mem_addr_q[p] <= '0;
        mem_d_q[p]    <= '0;
      end
      for (int s = 0; s < TL; s++) begin
        tag_v_q[s] <= '0;
        for (int p = 0; p < PORTS; p++)
          tag_i_q[s][p] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      mem_en_q <= mem_en_d;
      for (int p = 0; p < PORTS; p++) begin
        mem_addr_q[p] <= mem_addr_d[p];
        mem_d_q[p]    <= mem_d_d[p];
      end
      for (int s = 0; s < TL; s++) begin
        tag_v_q[s] <= tag_v_d[s];
        for (int p = 0; p < PORTS; p++)
          tag_i_q[s][p] <= tag_i_d[s][p];
      end
    end
  end

  assign mem_en = mem_en_q;
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      mem_addr[p] = mem_addr_q[p];
      mem_d[p]    = mem_d_q[p];
    end
  end

  // A requester issues at most one request per cycle, so at most one
  // port can return to it in a given cycle; OR-merge is safe.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < REQS; i++) begin
      rsp_data[i] = '0;
      for (int p = 0; p < PORTS; p++)
        if (tag_v_q[MEM_LAT][p]
            && tag_i_q[MEM_LAT][p] == PW'(i)) begin
          rsp_valid[i] = 1'b1;
          rsp_data[i]  = rsp_data[i] | mem_q[p];
        end
    end
  end

`ifdef MPM_SCHED_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d;
  logic [31:0] stat_conflicts_q, stat_conflicts_d;
  logic [32:0] g_sum, c_sum;

  always_comb begin
    g_sum = {1'b0, stat_grants_q} + 33'(n_gnt);
    c_sum = {1'b0, stat_conflicts_q} + 33'(n_conf);
    stat_grants_d    = g_sum[32] ? '1 : g_sum[31:0];
    stat_conflicts_d = c_sum[32] ? '1 : c_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_q    <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_grants_q    <= stat_grants_d;
      stat_conflicts_q <= stat_conflicts_d;
    end
  end

  assign stat_grants    = stat_grants_q;
  assign stat_conflicts = stat_conflicts_q;
`else
  logic unused_stats;
  assign unused_stats   = ^{n_conf};
  assign stat_grants    = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_mpm_port_scheduler.sv
// tb_mpm_port_scheduler: directed stimulus with a queued scoreboard of
// expected read responses, checked by an independent response monitor.
module tb_mpm_port_scheduler;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 512;
  localparam int PORTS   = 4;
  localparam int REQS    = 8;
  localparam int MEM_LAT = 1;
  localparam int AW      = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REQS-1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [AW-1:0]    req_addr [REQS];
  logic [WIDTH-1:0] req_d [REQS];
  logic [WIDTH-1:0] rsp_data [REQS];
  logic [AW-1:0]    mem_addr [PORTS];
  logic [PORTS-1:0] mem_en;
  logic [WIDTH-1:0] mem_d [PORTS];
  logic [WIDTH-1:0] mem_q [PORTS];
  logic [31:0]      stat_grants, stat_conflicts;

  int checks = 0;
  int passes = 0;
  longint exp_g = 0;
  longint exp_c = 0;

  typedef logic [WIDTH-1:0] dq_t [$];
  dq_t exp_q [REQS];
  logic [WIDTH-1:0] mem [DEPTH];

  int cnt [REQS];
  int last [REQS];
  int maxgap [REQS];

  always #5 clk = ~clk;

  mpm_port_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS),
    .REQS(REQS), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_d(req_d),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_d(mem_d), .mem_q(mem_q),
    .stat_grants(stat_grants),
    .stat_conflicts(stat_conflicts)
  );

  // Memory model: one-cycle registered read, writes land at the edge.
  always @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (mem_en[p]) mem[mem_addr[p]] <= mem_d[p];
      mem_q[p] <= mem[mem_addr[p]];
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Response monitor.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < REQS; i++)
        if (rsp_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            $display("FAIL rsp_unexpected: req %0d data %0h",
                     i, rsp_data[i]);
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i]), 64'(e));
          end
        end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: %0d/%0d", passes, checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
    for (int i = 0; i < REQS; i++) begin
      req_addr[i] = '0;
      req_d[i]    = '0;
    end
  endtask

  task automatic drive(input int i, input logic we,
                       input int a, input logic [WIDTH-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = AW'(a);
    req_d[i]     = d;
  endtask

  task automatic stats_chk(input string tag);
`ifdef MPM_SCHED_STATS_EN
    check({tag, "_grants"}, 64'(stat_grants), exp_g);
    check({tag, "_conflicts"}, 64'(stat_conflicts), exp_c);
`else
    check({tag, "_grants"}, 64'(stat_grants), 64'd0);
    check({tag, "_conflicts"}, 64'(stat_conflicts), 64'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < REQS; i++) drive(i, 1'b0, 100 + i, '0);
    repeat (3) tick();
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr0", 64'(mem_addr[0]), 64'd0);
    check("rst_mem_d3", 64'(mem_d[3]), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    stats_chk("rst");

    // First cycle out of reset: requesters 0..3, then 4..7.
    rst_n = 1'b1;
    #1;
    check("first_ready", 64'(req_ready), 64'h0F);
    for (int i = 0; i < 4; i++) exp_q[i].push_back('0);
    exp_g += 4;
    tick();
    check("first_mem_addr0", 64'(mem_addr[0]), 64'd100);
    check("first_mem_addr3", 64'(mem_addr[3]), 64'd103);
    check("first_mem_en", 64'(mem_en), 64'd0);
    check("second_ready", 64'(req_ready), 64'hF0);
    for (int i = 4; i < 8; i++) exp_q[i].push_back('0);
    exp_g += 4;
    tick();
    idle();
    repeat (4) tick();

    // Write then read-after-write on the next cycle.
    drive(2, 1'b1, 5, 32'hA5A5A5A5);
    #1;
    check("wr5_ready", 64'(req_ready), 64'h04);
    exp_g += 1;
    tick();
    check("wr5_mem_en", 64'(mem_en), 64'h1);
    check("wr5_mem_addr0", 64'(mem_addr[0]), 64'd5);
    check("wr5_mem_d0", 64'(mem_d[0]), 64'hA5A5A5A5);
    idle();
    drive(3, 1'b0, 5, '0);
    #1;
    check("rd5_ready", 64'(req_ready), 64'h08);
    exp_q[3].push_back(32'hA5A5A5A5);
    exp_g += 1;
    tick();
    idle();
    repeat (3) tick();

    // Write-write same address with ptr at 0.
    drive(0, 1'b1, 9, 32'h11111111);
    drive(1, 1'b1, 9, 32'h22222222);
    #1;
    check("ww_ready", 64'(req_ready), 64'h01);
    exp_g += 1;
    exp_c += 1;
    tick();
    req_valid[0] = 1'b0;
    #1;
    check("ww_retry_ready", 64'(req_ready), 64'h02);
    exp_g += 1;
    tick();
    idle();
    drive(4, 1'b0, 9, '0);
    #1;
    check("ww_rd_ready", 64'(req_ready), 64'h10);
    exp_q[4].push_back(32'h22222222);
    exp_g += 1;
    tick();
    idle();
    repeat (3) tick();
    stats_chk("ww");

    // ptr is 1: write by 2 wins, same-address read by 3 deferred.
    drive(2, 1'b1, 7, 32'h77777777);
    drive(3, 1'b0, 7, '0);
    #1;
    check("wr_rd_ready", 64'(req_ready), 64'h04);
    exp_g += 1;
    exp_c += 1;
    tick();
    req_valid[2] = 1'b0;
    #1;
    check("rd_retry_ready", 64'(req_ready), 64'h08);
    exp_q[3].push_back(32'h77777777);
    exp_g += 1;
    tick();
    idle();
    drive(4, 1'b0, 5, '0);
    drive(5, 1'b0, 5, '0);
    #1;
    check("rr_ready", 64'(req_ready), 64'h30);
    exp_q[4].push_back(32'hA5A5A5A5);
    exp_q[5].push_back(32'hA5A5A5A5);
    exp_g += 2;
    tick();
    idle();
    repeat (4) tick();
    stats_chk("hz");

    // Fairness: all requesters valid for 4*REQS cycles.
    for (int i = 0; i < REQS; i++) begin
      cnt[i] = 0;
      last[i] = -1;
      maxgap[i] = 0;
      drive(i, 1'b0, 5, '0);
    end
    for (int c = 0; c < 4 * REQS; c++) begin
      #1;
      for (int i = 0; i < REQS; i++)
        if (req_ready[i]) begin
          exp_q[i].push_back(32'hA5A5A5A5);
          cnt[i]++;
          if (c - last[i] > maxgap[i]) maxgap[i] = c - last[i];
          last[i] = c;
        end
      tick();
    end
    idle();
    exp_g += 4 * REQS * PORTS;
    for (int i = 0; i < REQS; i++) begin
      check($sformatf("fair_cnt[%0d]", i), 64'(cnt[i]), 64'd16);
      check($sformatf("fair_gap_ok[%0d]", i),
            64'(maxgap[i] <= REQS), 64'd1);
    end
    repeat (4) tick();
    stats_chk("fair");
    for (int i = 0; i < REQS; i++)
      check($sformatf("drain_q[%0d]", i), 64'(exp_q[i].size()), 64'd0);

    // Reset one cycle after accepting reads: none may return.
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 5, '0);
    #1;
    check("pre_rst_ready", 64'(req_ready), 64'h0F);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_mem_addr0", 64'(mem_addr[0]), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    exp_g = 0;
    exp_c = 0;
    #1;
    stats_chk("post_rst");
    repeat (5) tick();
    for (int i = 0; i < REQS; i++)
      check($sformatf("end_q[%0d]", i), 64'(exp_q[i].size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
